// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM capture block: FSM state encoding,
// default measurement width and the saturating-counter maximum.
package pwm_pkg;

  localparam int unsigned PWM_SIZE_DEF = 16;

  // All-ones value of a default-width counter: the longest measurable span.
  localparam logic [PWM_SIZE_DEF-1:0] CNT_MAX_DEF = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HIGH    = 2'd1,
    LOW     = 2'd2,
    TIMEOUT = 2'd3
  } state_e;

endpackage

// File: rtl/pwm_capture_if.sv
// Measurement bus of the PWM capture block: the raw PWM input plus the
// period/duty results and status flags. master = capture block, slave = consumer.
interface pwm_capture_if
  import pwm_pkg::*;
#(
  parameter int PWM_SIZE = PWM_SIZE_DEF
);

  logic                pwm_in;
  logic [PWM_SIZE-1:0] meas_period;
  logic [PWM_SIZE-1:0] meas_duty;
  logic                meas_valid;
  logic                timeout;
  logic                stuck_level;

  modport master (
    input  pwm_in,
    output meas_period, meas_duty, meas_valid, timeout, stuck_level
  );

  modport slave (
    output pwm_in,
    input  meas_period, meas_duty, meas_valid, timeout, stuck_level
  );

endinterface

// File: rtl/pwm_in_sync.sv
// Input conditioning for pwm_capture: synchroniser, optional glitch filter
// (PWM_CAPTURE_GLITCH_FILTER_EN) and registered edge detector.
module pwm_in_sync
  import pwm_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall
);

  if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_bad_param
    $error("pwm_in_sync: SYNC_STAGES must be >= 2 and FILTER_LEN >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int              RUN_W    = $clog2(FILTER_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILTER_LEN - 1);

  logic [RUN_W-1:0] run_q;
  logic             filt_q;

  // The filtered level follows only after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= 1'b0;
      run_q  <= '0;
    end else if (sync_q[SYNC_STAGES-1] != filt_q) begin
      if (run_q == RUN_LAST) begin
        filt_q <= sync_q[SYNC_STAGES-1];
        run_q  <= '0;
      end else begin
        run_q <= run_q + 1'b1;
      end
    end else begin
      run_q <= '0;
    end
  end

  assign s = filt_q;
`else
  assign s = sync_q[SYNC_STAGES-1];
`endif

  // rise/fall are registered, so level (= s_d) is aligned with the pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_d  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s_d  <= s;
      rise <= s & ~s_d;
      fall <= ~s & s_d;
    end
  end

  assign level = s_d;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of pwm_in in clk cycles and flags
// a static input. Optional glitch filter: define PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int PWM_SIZE    = PWM_SIZE_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic          clk,
  input  logic          rst,
  pwm_capture_if.master bus
);

  localparam logic [PWM_SIZE-1:0] CNT_MAX = '1;

  logic                level;
  logic                rise;
  logic                fall;
  logic                at_max;
  state_e              state;
  logic [PWM_SIZE-1:0] cnt;
  logic [PWM_SIZE-1:0] duty_hold;
  logic [PWM_SIZE-1:0] period_q;
  logic [PWM_SIZE-1:0] duty_q;
  logic                valid_q;
  logic                stuck_q;

  pwm_in_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_in_sync (
    .clk   (clk),
    .rst   (rst),
    .pwm_in(bus.pwm_in),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  // cnt read in an edge cycle is the number of cycles since the previous rise.
  always_ff @(posedge clk) begin
    if (rst)                cnt <= '0;
    else if (rise)          cnt <= PWM_SIZE'(1);
    else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
  end

  assign at_max = (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      duty_hold <= '0;
      period_q  <= '0;
      duty_q    <= '0;
      valid_q   <= 1'b0;
      stuck_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise) state <= HIGH;
        end
        HIGH: begin
          if (fall) begin
            duty_hold <= cnt;
            state     <= LOW;
          end else if (at_max && !rise) begin
            stuck_q <= level;
            state   <= TIMEOUT;
          end
        end
        LOW: begin
          if (rise) begin
            period_q <= cnt;
            duty_q   <= duty_hold;
            valid_q  <= 1'b1;
            state    <= HIGH;
          end else if (at_max && !fall) begin
            stuck_q <= level;
            state   <= TIMEOUT;
          end
        end
        TIMEOUT: begin
          // Re-arm only; the interrupted period is never reported.
          if (rise) state <= HIGH;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.meas_period = period_q;
  assign bus.meas_duty   = duty_q;
  assign bus.meas_valid  = valid_q;
  assign bus.timeout     = (state == TIMEOUT);
  assign bus.stuck_level = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: waveform scenarios and random traffic
// compared cycle by cycle against an edge-time reference model.
module tb_pwm_capture;
  import pwm_pkg::*;

  localparam int PW   = 8;
  localparam int SYNC = 2;
  localparam int FL   = 4;
  localparam int MAXC = (1 << PW) - 1;
  localparam int DLY  = SYNC + 2;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int LAT = SYNC + 2 + FL;
`else
  localparam int LAT = SYNC + 2;
`endif

  typedef struct packed {
    logic          valid;
    logic [PW-1:0] period;
    logic [PW-1:0] duty;
    logic          timeout;
    logic          stuck;
  } obs_t;

  logic clk = 1'b0;
  logic rst;

  pwm_capture_if #(.PWM_SIZE(PW)) bus ();

  pwm_capture #(
    .PWM_SIZE   (PW),
    .SYNC_STAGES(SYNC),
    .FILTER_LEN (FL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int   nvec = 0;
  int   nmis = 0;
  obs_t obs;
  obs_t expv;
  obs_t exp_q[$];

  // Reference model: works on the sequence of sampled input levels and edge
  // times; every result appears DLY cycles after the sample that caused it.
  int   samp = 0;
  int   m_last_rise;
  int   m_fall_at;
  logic m_pl;
  bit   m_armed, m_fall_seen, m_to;
  obs_t m_hold;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic m_f;
  int   m_run;
`endif

  function automatic string show(obs_t o);
    return $sformatf("v=%0b p=%0d d=%0d to=%0b st=%0b",
                     o.valid, o.period, o.duty, o.timeout, o.stuck);
  endfunction

  task automatic model_reset();
    m_pl        = 1'b0;
    m_armed     = 1'b0;
    m_fall_seen = 1'b0;
    m_to        = 1'b0;
    m_last_rise = 0;
    m_fall_at   = 0;
    m_hold      = '0;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    m_f   = 1'b0;
    m_run = 0;
`endif
    exp_q.delete();
    repeat (DLY) exp_q.push_back('0);
  endtask

  task automatic model_sample(input logic l);
    logic cur;
    obs_t e;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    cur = m_f;
    if (l != m_f) begin
      m_run++;
      if (m_run == FL) begin
        m_f   = l;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
`else
    cur = l;
`endif
    e       = m_hold;
    e.valid = 1'b0;
    if (cur && !m_pl) begin
      if (m_armed && !m_to && m_fall_seen) begin
        e.valid  = 1'b1;
        e.period = PW'(samp - m_last_rise);
        e.duty   = PW'(m_fall_at - m_last_rise);
      end
      m_armed     = 1'b1;
      m_to        = 1'b0;
      m_fall_seen = 1'b0;
      m_last_rise = samp;
    end else if (!cur && m_pl) begin
      if (m_armed && !m_to && !m_fall_seen) begin
        m_fall_seen = 1'b1;
        m_fall_at   = samp;
      end
    end else if (m_armed && !m_to && (samp - m_last_rise) >= MAXC) begin
      m_to    = 1'b1;
      e.stuck = !m_fall_seen;
    end
    e.timeout = m_to;
    m_pl      = cur;
    m_hold    = e;
    exp_q.push_back(e);
    samp++;
  endtask

  // Sample the DUT on the falling edge, then drive the next input value.
  task automatic step(input logic lvl, input logic do_rst);
    @(negedge clk);
    obs  = {bus.meas_valid, bus.meas_period, bus.meas_duty, bus.timeout, bus.stuck_level};
    expv = exp_q.pop_front();
    bus.pwm_in = lvl;
    rst        = do_rst;
    if (do_rst) model_reset();
    else        model_sample(lvl);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'($urandom_range(0, 1)), 1'b1);
      nvec++;
      if (obs !== expv) begin
        nmis++;
        $display("FAIL reset_cycle: got %s, want %s", show(obs), show(expv));
      end
    end
    nvec++;
    if (obs !== '0) begin
      nmis++;
      $display("FAIL reset_zero: got %s, want all zero", show(obs));
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0);
      nvec++;
      if (obs !== expv) begin
        nmis++;
        $display("FAIL reset_idle: got %s, want %s", show(obs), show(expv));
      end
    end
  endtask

  task automatic test_steady();
    int nvalid = 0;
    for (int p = 0; p < 6; p++) begin
      for (int c = 0; c < 16; c++) begin
        step(c < 8, 1'b0);
        nvec++;
        if (obs !== expv) begin
          nmis++;
          $display("FAIL steady_8_8: got %s, want %s", show(obs), show(expv));
        end
        if (obs.valid) nvalid++;
      end
    end
    nvec++;
    if (nvalid != 5) begin
      nmis++;
      $display("FAIL steady_valid_count: got %0d, want 5", nvalid);
    end
    nvec++;
    if (obs.period !== PW'(16) || obs.duty !== PW'(8)) begin
      nmis++;
      $display("FAIL steady_values: got %0d/%0d, want 16/8", obs.period, obs.duty);
    end
  endtask

  task automatic test_duty_change();
    int want_d[6] = '{8, 4, 4, 4, 12, 12};
    int nvalid = 0;
    int hi;
    for (int p = 0; p < 6; p++) begin
      hi = (p < 3) ? 4 : 12;
      for (int c = 0; c < 16; c++) begin
        step(c < hi, 1'b0);
        nvec++;
        if (obs !== expv) begin
          nmis++;
          $display("FAIL duty_change: got %s, want %s", show(obs), show(expv));
        end
        if (obs.valid) begin
          nvec++;
          if (nvalid >= 6 || obs.period !== PW'(16) || obs.duty !== PW'(want_d[nvalid])) begin
            nmis++;
            $display("FAIL duty_step%0d: got %0d/%0d, want 16/%0d", nvalid, obs.period,
                     obs.duty, want_d[nvalid % 6]);
          end
          nvalid++;
        end
      end
    end
    nvec++;
    if (nvalid != 6) begin
      nmis++;
      $display("FAIL duty_valid_count: got %0d, want 6", nvalid);
    end
  endtask

  task automatic test_timeout();
    bit first = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b0);
      nvec++;
      if (obs !== expv) begin
        nmis++;
        $display("FAIL timeout_hold: got %s, want %s", show(obs), show(expv));
      end
    end
    nvec++;
    if (obs.timeout !== 1'b1 || obs.stuck !== 1'b1) begin
      nmis++;
      $display("FAIL timeout_entry: got to=%0b st=%0b, want to=1 st=1", obs.timeout, obs.stuck);
    end
    for (int p = 0; p < 5; p++) begin
      for (int c = 0; c < 10; c++) begin
        step(c < 5, 1'b0);
        nvec++;
        if (obs !== expv) begin
          nmis++;
          $display("FAIL timeout_recover: got %s, want %s", show(obs), show(expv));
        end
        if (obs.valid && first) begin
          first = 1'b0;
          nvec++;
          if (obs.period !== PW'(10) || obs.duty !== PW'(5) || obs.timeout !== 1'b0) begin
            nmis++;
            $display("FAIL timeout_first_valid: got %0d/%0d to=%0b, want 10/5 to=0",
                     obs.period, obs.duty, obs.timeout);
          end
        end
      end
    end
    nvec++;
    if (first) begin
      nmis++;
      $display("FAIL timeout_no_valid: got none, want 10/5 after recovery");
    end
  endtask

  task automatic test_min_pulse();
    int lat = -1;
    for (int i = 0; i < 40; i++) begin
      step((i >= 20) ? 1'(i % 2 == 0) : 1'b0, 1'b0);
      nvec++;
      if (obs !== expv) begin
        nmis++;
        $display("FAIL min_pulse: got %s, want %s", show(obs), show(expv));
      end
    end
`ifndef PWM_CAPTURE_GLITCH_FILTER_EN
    nvec++;
    if (obs.period !== PW'(2) || obs.duty !== PW'(1)) begin
      nmis++;
      $display("FAIL min_pulse_values: got %0d/%0d, want 2/1", obs.period, obs.duty);
    end
`endif
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0);
      nvec++;
      if (obs !== expv) begin
        nmis++;
        $display("FAIL latency_pre: got %s, want %s", show(obs), show(expv));
      end
    end
    step(1'b1, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      step(k < 6, 1'b0);
      nvec++;
      if (obs !== expv) begin
        nmis++;
        $display("FAIL latency_wave: got %s, want %s", show(obs), show(expv));
      end
      if (obs.valid && lat < 0) lat = k;
    end
    nvec++;
    if (lat != LAT) begin
      nmis++;
      $display("FAIL latency: got %0d cycles, want %0d", lat, LAT);
    end
  endtask

  task automatic test_reset_mid_high();
    int nvalid = 0;
    for (int i = 0; i < 35; i++) begin
      step((i % 16) < 8, 1'b0);
      nvec++;
      if (obs !== expv) begin
        nmis++;
        $display("FAIL mid_reset_pre: got %s, want %s", show(obs), show(expv));
      end
    end
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    nvec++;
    if (obs !== '0) begin
      nmis++;
      $display("FAIL mid_reset_zero: got %s, want all zero", show(obs));
    end
    for (int i = 0; i < 60; i++) begin
      step((i < 3) || ((i - 11) % 16 >= 0 && (i - 11) % 16 < 8 && i >= 11), 1'b0);
      nvec++;
      if (obs !== expv) begin
        nmis++;
        $display("FAIL mid_reset_post: got %s, want %s", show(obs), show(expv));
      end
      if (i < 8 && obs.valid) nvalid++;
    end
    nvec++;
    if (nvalid != 0) begin
      nmis++;
      $display("FAIL mid_reset_early_valid: got %0d, want 0", nvalid);
    end
  endtask

  task automatic test_random();
    int h, l;
    for (int p = 0; p < 25; p++) begin
      h = $urandom_range(1, 20);
      l = $urandom_range(1, 20);
      for (int c = 0; c < h + l; c++) begin
        step(c < h, 1'b0);
        nvec++;
        if (obs !== expv) begin
          nmis++;
          $display("FAIL random h=%0d l=%0d: got %s, want %s", h, l, show(obs), show(expv));
        end
      end
    end
  endtask

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  task automatic test_glitch_filter();
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 32; c++) begin
        step((c < 20) && !(c == 8 || c == 9), 1'b0);
        nvec++;
        if (obs !== expv) begin
          nmis++;
          $display("FAIL glitch: got %s, want %s", show(obs), show(expv));
        end
      end
    end
    nvec++;
    if (obs.period !== PW'(32) || obs.duty !== PW'(20)) begin
      nmis++;
      $display("FAIL glitch_values: got %0d/%0d, want 32/20", obs.period, obs.duty);
    end
  endtask
`endif

  task automatic test_drain();
    for (int i = 0; i < LAT + 4; i++) begin
      step(1'b0, 1'b0);
      nvec++;
      if (obs !== expv) begin
        nmis++;
        $display("FAIL drain: got %s, want %s", show(obs), show(expv));
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    bus.pwm_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    test_reset();
    test_steady();
    test_duty_change();
    test_timeout();
    test_min_pulse();
    test_reset_mid_high();
    test_random();
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    test_glitch_filter();
`endif
    test_drain();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
